// File: rtl/jk_drive_sequencer.sv
// Command sequencer for a negative-edge JK flop stage: buffers {op, count} commands in a
// small FIFO, drives the jk bus for the requested cycle count and tracks the flop's Q.
module jk_drive_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [1:0]       jk,
  output logic             busy,
  output logic             done,
  output logic             q_model,
  output logic             state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_op/cmd_count must be stable while cmd_valid is high and cmd_ready is low.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   occ;
  logic [1:0]       mem_op  [DEPTH];
  logic [CNT_W-1:0] mem_cnt [DEPTH];
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [1:0]       jk_nxt;
  logic             done_nxt;
  logic             full, empty, push, pop;
  logic [1:0]       head_op;
  logic [CNT_W-1:0] head_cnt;

  assign full      = (occ == (PTR_W+1)'(DEPTH));
  assign empty     = (occ == '0);
  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state == ISSUE) || !empty;
  assign state_dbg = state;

  assign head_op  = mem_op[rptr];
  // A zero count still drives the op for one cycle.
  assign head_cnt = (mem_cnt[rptr] == '0) ? CNT_W'(1) : mem_cnt[rptr];

  always_comb begin
    state_nxt = state;
    jk_nxt    = jk;
    rem_nxt   = rem;
    done_nxt  = 1'b0;
    pop       = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      jk_nxt    = 2'b00;
      rem_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          jk_nxt = 2'b00;
          if (!empty) begin
            pop       = 1'b1;
            jk_nxt    = head_op;
            rem_nxt   = head_cnt;
            state_nxt = ISSUE;
          end
        end
        ISSUE: begin
          if (rem > CNT_W'(1)) begin
            rem_nxt = rem - CNT_W'(1);
          end else if (!empty) begin
            // Final cycle of this command: chain the next one with no bubble.
            done_nxt = 1'b1;
            pop      = 1'b1;
            jk_nxt   = head_op;
            rem_nxt  = head_cnt;
          end else begin
            done_nxt  = 1'b1;
            jk_nxt    = 2'b00;
            rem_nxt   = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          jk_nxt    = 2'b00;
          rem_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      jk    <= 2'b00;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      jk    <= jk_nxt;
      rem   <= rem_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (abort) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wptr]  <= cmd_op;
      mem_cnt[wptr] <= cmd_count;
    end
  end

  // Q follows the code that was on the bus during the cycle now ending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_model <= 1'b0;
    end else begin
      case (jk)
        2'b01:   q_model <= 1'b0;
        2'b10:   q_model <= 1'b1;
        2'b11:   q_model <= ~q_model;
        default: q_model <= q_model;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Table-driven bench for jk_drive_sequencer: each vector drives one edge of inputs and
// lists the outputs expected just after that edge; resets and async cases are hand-written.
module tb_jk_drive_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_count;
  logic       abort;
  logic [1:0] jk;
  logic       busy;
  logic       done;
  logic       q_model;
  logic       state_dbg;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic [3:0] cnt;
    logic       ab;
    logic [1:0] e_jk;
    logic       e_done;
    logic       e_busy;
    logic       e_ready;
    logic       e_q;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];

  jk_drive_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .abort     (abort),
    .jk        (jk),
    .busy      (busy),
    .done      (done),
    .q_model   (q_model),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_all(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {jk, done, busy, cmd_ready, q_model};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got {jk,done,busy,ready,q}=%b required %b", tag, got, exp);
    end
  endtask

  task automatic add_v(input logic v, input logic [1:0] op, input logic [3:0] c, input logic ab,
                       input logic [1:0] ejk, input logic ed, input logic eb, input logic er,
                       input logic eq);
    vec_t t;
    t.valid = v; t.op = op; t.cnt = c; t.ab = ab;
    t.e_jk = ejk; t.e_done = ed; t.e_busy = eb; t.e_ready = er; t.e_q = eq;
    vecs.push_back(t);
  endtask

  // driver: one vector per rising edge, checked #1 after the edge
  task automatic run_vecs(input string name);
    logic [5:0] exp;
    for (int i = 0; i < vecs.size(); i++) begin
      cmd_valid = vecs[i].valid;
      cmd_op    = vecs[i].op;
      cmd_count = vecs[i].cnt;
      abort     = vecs[i].ab;
      exp_q.push_back({vecs[i].e_jk, vecs[i].e_done, vecs[i].e_busy, vecs[i].e_ready, vecs[i].e_q});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check_all($sformatf("%s[%0d]", name, i), exp);
    end
    vecs.delete();
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic do_reset(input string name);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 4'd0; abort = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all({name, "_reset"}, 6'b00_0_0_1_0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 4'd0; abort = 1'b0;

    // single set command, count 3
    do_reset("single");
    //    v  op     cnt   ab  jk     d  b  r  q
    add_v(1, 2'b10, 4'd3, 0, 2'b00, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b10, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b10, 0, 1, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b10, 0, 1, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 1, 0, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 0, 0, 1, 1);
    run_vecs("single");

    // back-to-back toggle, toggle(count 0), clear x2
    do_reset("b2b");
    add_v(1, 2'b11, 4'd1, 0, 2'b00, 0, 1, 1, 0);
    add_v(1, 2'b11, 4'd0, 0, 2'b11, 0, 1, 1, 0);
    add_v(1, 2'b01, 4'd2, 0, 2'b11, 1, 1, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b01, 1, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b01, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 1, 0, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 0, 0, 1, 0);
    run_vecs("b2b");

    // fill: one active {11,15} plus four queued; max count runs 15 cycles
    do_reset("full");
    add_v(1, 2'b11, 4'd15, 0, 2'b00, 0, 1, 1, 0);
    add_v(1, 2'b11, 4'd15, 0, 2'b11, 0, 1, 1, 0);
    add_v(1, 2'b11, 4'd15, 0, 2'b11, 0, 1, 1, 1);
    add_v(1, 2'b11, 4'd15, 0, 2'b11, 0, 1, 1, 0);
    add_v(1, 2'b11, 4'd15, 0, 2'b11, 0, 1, 0, 1);
    for (int e = 6; e <= 16; e++) begin
      add_v(0, 2'b00, 4'd0, 0, 2'b11, 0, 1, 0, logic'((e - 2) & 1));
    end
    add_v(0, 2'b00, 4'd0, 0, 2'b11, 1, 1, 1, 1);
    run_vecs("full");

    // abort mid-command with two queued; command presented during abort is dropped
    do_reset("abort");
    add_v(1, 2'b10, 4'd5, 0, 2'b00, 0, 1, 1, 0);
    add_v(1, 2'b01, 4'd2, 0, 2'b10, 0, 1, 1, 0);
    add_v(1, 2'b11, 4'd3, 0, 2'b10, 0, 1, 1, 1);
    add_v(1, 2'b11, 4'd1, 1, 2'b00, 0, 0, 0, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 0, 0, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 0, 0, 1, 1);
    run_vecs("abort");

    // asynchronous reset between edges while issuing
    do_reset("async");
    add_v(1, 2'b11, 4'd4, 0, 2'b00, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b11, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b11, 0, 1, 1, 1);
    run_vecs("async_pre");
    #2;
    reset = 1'b0;
    #1;
    check_all("async_drop", 6'b00_0_0_1_0);
    @(negedge clk);
    reset = 1'b1;
    add_v(1, 2'b10, 4'd1, 0, 2'b00, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b10, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 1, 0, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 0, 0, 1, 1);
    run_vecs("async_post");

    // hold with count 0 after a set: one hold cycle, Q unchanged, own done pulse
    do_reset("hold0");
    add_v(1, 2'b10, 4'd1, 0, 2'b00, 0, 1, 1, 0);
    add_v(1, 2'b00, 4'd0, 0, 2'b10, 0, 1, 1, 0);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 1, 1, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 1, 0, 1, 1);
    add_v(0, 2'b00, 4'd0, 0, 2'b00, 0, 0, 1, 1);
    run_vecs("hold0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
